hs32_lsu: RTL
=============

Name: hs32_lsu

Overview:
- Parametrised load/store sequencer for the next-generation execute stage. It replaces the fixed single-word TM1/TM2 memory states with a standalone unit.
- Executes byte, half, word or doubleword accesses, with 1..MAXBEATS consecutive beats, lane steering, byte enables, sign extension and fault reporting.
- Sits between the execute FSM (req/rdy handshake) and the memory arbiter (reqm/rdym handshake).

Parameters:
- AW, 32, address width.
- DW, 32, data width in bits; power of two, at least 32.
- MAXBEATS, 4, maximum beats per request; power of two, at least 2.
- TIMEOUT, 255, stall-cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; accepted on a cycle where req && rdy.
- rdy  out  1  unit idle, can accept req.
- rw  in  1  0 = load, 1 = store.
- size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- sext  in  1  sign-extend load data.
- base  in  AW  first beat address.
- nbeat  in  $clog2(MAXBEATS)  beats minus one.
- wdata  in  DW  store data for the current beat, LSB-aligned.
- wnext  out  1  current store beat consumed; present the next beat's data.
- rdata  out  DW  extracted load data.
- rvalid  out  1  one-cycle pulse per load beat.
- done  out  1  one-cycle pulse at end of request.
- fault  out  1  qualifies done; request ended abnormally.
- fcode  out  2  0 = none, 1 = misaligned, 2 = timeout, 3 = bad size.
- addr  out  AW  memory address.
- dtwm  out  DW  memory write data.
- be  out  DW/8  byte enables.
- dtrm  in  DW  memory read data.
- reqm  out  1  memory request.
- rdym  in  1  memory ready.
- rw_mem  out  1  1 = write.

Behaviour:
Reset values:
- All outputs 0 except rdy = 1.
- State IDLE; beat counter 0.
- Reset asserted mid-transfer: reqm drops at the next edge; no done, rvalid or wnext is produced.

States: IDLE, ACC, GAP, END.
- rdy = (state == IDLE). req while busy is ignored.

Acceptance (IDLE, req && rdy), at edge 0:
- Latch rw, size, sext, nbeat.
- If size > log2(DW/8): go to END with fcode 3.
- Else if base is not aligned to 1<<size: go to END with fcode 1.
- Else: go to ACC. At the same edge, set addr = base, reqm = 1, rw_mem = rw, be, and dtwm from wdata.

Lane steering (lane = addr[log2(DW/8)-1:0]):
- be = ((1<<(1<<size))-1) << lane.
- dtwm = wdata's low (8<<size) bits replicated across all lanes.
- Load data = dtrm >> (8*lane), truncated to 8<<size bits, then zero- or sign-extended per sext.

ACC:
- reqm is held high until rdym. The cycle k with reqm && rdym completes the beat.
- wnext is combinational: reqm && rdym && rw_mem && beats remain.
- At edge k+1: reqm = 0. For loads, rdata is valid and rvalid = 1 during cycle k+1.
- If beats remain, go to GAP. Else go to IDLE with done = 1 and rdy = 1 during cycle k+1.

GAP (exactly one cycle with reqm low):
- addr += 1<<size, modulo 2^AW (wrap, no fault).
- Resample wdata into dtwm and recompute be.
- reqm = 1 at the end of GAP; return to ACC.

END (one cycle, no memory access):
- done = 1, fault = 1, fcode held. Next state IDLE.

Other rules:
- fcode and fault remain valid only while done is high; otherwise 0.
- rdym while reqm is low is ignored.

Optional Feature:
Macro HS32_LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to ACC and increments each ACC cycle with reqm && !rdym. When it reaches TIMEOUT, at the next edge: reqm = 0, go to END, fcode = 2. Remaining beats are abandoned and no rvalid is produced for the aborted beat.
- Undefined: ACC waits indefinitely, fcode 2 is never produced, and the counter is absent.

Test Plan:
1. Aligned word load: base = 0x100, size = 2, nbeat = 0, rdym 2 cycles after reqm, dtrm = 0xDEADBEEF -> be = 4'hF, rdata = 0xDEADBEEF, rvalid and done pulse together, fault = 0.
2. Signed byte load: base = 0x103, size = 0, sext = 1, dtrm = 0x80xxxxxx -> be = 4'b1000, rdata = 0xFFFFFF80. Repeat with sext = 0 -> rdata = 0x00000080.
3. 4-beat halfword store: base = 0x200, wdata = 0x1111, 0x2222, 0x3333, 0x4444 advanced on wnext -> addr sequence 0x200, 0x202, 0x204, 0x206; be sequence 0011, 1100, 0011, 1100; dtwm = 0x11111111 etc. Exactly 3 wnext pulses, one cycle of reqm low between beats, done after the 4th beat.
4. Faults: base = 0x102 with size = 2 -> done and fault with fcode = 1, and reqm never rises. size = 3 with DW = 32 -> fcode = 3.
5. Wrap and reset: base = 0xFFFFFFFC, size = 2, nbeat = 1 -> second addr = 0x00000000. Reset asserted while reqm = 1 -> reqm = 0 and rdy = 1 after one edge, with no done.
6. Timeout (macro on, TIMEOUT = 8): rdym held low -> reqm drops after 8 stall cycles, then done with fcode = 2. Macro off -> reqm is still high after 1000 cycles.

Source files
------------

// File: rtl/hs32_lsu_if.sv
// hs32_lsu_if: memory-side bus between the load/store sequencer and the arbiter.
//
// Signals
//   addr    beat address (byte address)
//   dtwm    write data, lane-replicated
//   be      byte enables, one bit per data byte
//   dtrm    read data returned by memory
//   reqm    memory request, held until rdym
//   rdym    memory ready; completes a beat when seen with reqm
//   rw_mem  1 = write, 0 = read
//
// Modports
//   master  the sequencer (drives the request side)
//   slave   the memory/arbiter (drives dtrm and rdym)
interface hs32_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dtwm;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   dtrm;
    logic            reqm;
    logic            rdym;
    logic            rw_mem;

    modport master (
        output addr, dtwm, be, reqm, rw_mem,
        input  dtrm, rdym
    );

    modport slave (
        input  addr, dtwm, be, reqm, rw_mem,
        output dtrm, rdym
    );
endinterface

// File: rtl/hs32_lsu.sv
// hs32_lsu: multi-beat load/store sequencer between the execute FSM and the
// memory arbiter. Handles byte/half/word/doubleword accesses of 1..MAXBEATS
// consecutive beats with lane steering, byte enables, sign extension and
// fault reporting.
//
// Optional feature: define HS32_LSU_TIMEOUT_EN to abort a beat after TIMEOUT
// stall cycles (fcode 2). Without it the unit waits for rdym indefinitely.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   req / rdy    execute-side handshake; request accepted when both high
//   rw           0 = load, 1 = store
//   size         log2 of access bytes
//   sext         sign-extend load data
//   base         address of the first beat
//   nbeat        number of beats minus one
//   wdata        store data for the current beat, LSB aligned
//   wnext        current store beat consumed; present the next beat's data
//   rdata        extracted load data, valid with rvalid
//   rvalid       one-cycle pulse per load beat
//   done         one-cycle pulse at end of request
//   fault/fcode  abnormal end and its cause, valid only with done
//   mem          memory bus (hs32_lsu_if master modport)
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for req; rdy high
// ACC     | reqm high, waiting for rdym to complete the current beat
// GAP     | one cycle with reqm low; next beat's address/data prepared
// END     | fault report cycle; done, fault and fcode high, no access
module hs32_lsu #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAXBEATS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    output logic                        rdy,
    input  logic                        rw,
    input  logic [1:0]                  size,
    input  logic                        sext,
    input  logic [AW-1:0]               base,
    input  logic [$clog2(MAXBEATS)-1:0] nbeat,
    input  logic [DW-1:0]               wdata,
    output logic                        wnext,
    output logic [DW-1:0]               rdata,
    output logic                        rvalid,
    output logic                        done,
    output logic                        fault,
    output logic [1:0]                  fcode,
    hs32_lsu_if.master                  mem
);

    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam int BW = $clog2(MAXBEATS);
    localparam logic [2:0] MAXSZ = 3'(LW);

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_MIS  = 2'd1;
    localparam logic [1:0] FC_TMO  = 2'd2;
    localparam logic [1:0] FC_SIZE = 2'd3;

    if (DW < 32 || (DW & (DW - 1)) != 0) begin : g_bad_dw
        $error("hs32_lsu: DW must be a power of two and at least 32");
    end
    if (MAXBEATS < 2 || (MAXBEATS & (MAXBEATS - 1)) != 0) begin : g_bad_maxbeats
        $error("hs32_lsu: MAXBEATS must be a power of two and at least 2");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
        $error("hs32_lsu: TIMEOUT must be non-negative");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        GAP,
        END
    } state_t;

    state_t        state;
    logic [BW-1:0] beats_left;
    logic [1:0]    size_q;
    logic          sext_q;
    logic [AW-1:0] addr_next;

`ifdef HS32_LSU_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counts down the stall budget of the current beat; reaching zero on a
    // stall is the timeout condition.
    logic [TW-1:0] tmo_cnt;
`endif

    // Enables for the 1<<sz bytes starting at the given lane.
    function automatic logic [NB-1:0] lane_be(input logic [1:0] sz,
                                              input logic [LW-1:0] lane);
        logic [NB-1:0] r;
        int lo;
        int hi;
        lo = int'(lane);
        hi = lo + (1 << sz);
        r  = '0;
        for (int i = 0; i < NB; i++) begin
            r[i] = (i >= lo) && (i < hi);
        end
        return r;
    endfunction

    // Low (8<<sz) bits of d copied into every lane-sized slot of the bus.
    function automatic logic [DW-1:0] replicate(input logic [DW-1:0] d,
                                                input logic [1:0] sz);
        logic [DW-1:0] r;
        int n;
        n = 1 << sz;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = d[8*(i % n) +: 8];
        end
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, keep 1<<sz bytes, extend.
    function automatic logic [DW-1:0] extract(input logic [DW-1:0] d,
                                              input logic [LW-1:0] lane,
                                              input logic [1:0] sz,
                                              input logic sx);
        logic [DW-1:0] s;
        logic [DW-1:0] r;
        logic          fill;
        int n;
        s    = d >> {lane, 3'b000};
        n    = 1 << sz;
        fill = sx & s[8*n-1];
        r    = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = (i < n) ? s[8*i +: 8] : {8{fill}};
        end
        return r;
    endfunction

    always_comb begin
        addr_next = mem.addr + (AW'(1) << size_q);
    end

    assign rdy   = (state == IDLE);
    assign wnext = mem.reqm && mem.rdym && mem.rw_mem && (beats_left != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= '0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            mem.addr   <= '0;
            mem.dtwm   <= '0;
            mem.be     <= '0;
            mem.reqm   <= 1'b0;
            mem.rw_mem <= 1'b0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fcode      <= FC_NONE;
`ifdef HS32_LSU_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            // Pulses and fault reporting last a single cycle.
            rvalid <= 1'b0;
            done   <= 1'b0;
            fault  <= 1'b0;
            fcode  <= FC_NONE;

            case (state)
                IDLE: begin
                    if (req) begin
                        size_q     <= size;
                        sext_q     <= sext;
                        beats_left <= nbeat;
                        mem.rw_mem <= rw;
                        if ({1'b0, size} > MAXSZ) begin
                            state <= END;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            fcode <= FC_SIZE;
                        end else if ((base & ((AW'(1) << size) - AW'(1))) != '0) begin
                            state <= END;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            fcode <= FC_MIS;
                        end else begin
                            state    <= ACC;
                            mem.addr <= base;
                            mem.reqm <= 1'b1;
                            mem.be   <= lane_be(size, base[LW-1:0]);
                            mem.dtwm <= replicate(wdata, size);
`ifdef HS32_LSU_TIMEOUT_EN
                            tmo_cnt  <= TW'(TIMEOUT);
`endif
                        end
                    end
                end

                ACC: begin
                    if (mem.reqm && mem.rdym) begin
                        mem.reqm <= 1'b0;
                        if (!mem.rw_mem) begin
                            rdata  <= extract(mem.dtrm, mem.addr[LW-1:0], size_q, sext_q);
                            rvalid <= 1'b1;
                        end
                        if (beats_left != '0) begin
                            beats_left <= beats_left - 1'b1;
                            state      <= GAP;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
`ifdef HS32_LSU_TIMEOUT_EN
                    else if (tmo_cnt <= TW'(1)) begin
                        mem.reqm <= 1'b0;
                        state    <= END;
                        done     <= 1'b1;
                        fault    <= 1'b1;
                        fcode    <= FC_TMO;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end

                GAP: begin
                    // Address wraps modulo 2^AW; no fault on wrap.
                    mem.addr <= addr_next;
                    mem.be   <= lane_be(size_q, addr_next[LW-1:0]);
                    mem.dtwm <= replicate(wdata, size_q);
                    mem.reqm <= 1'b1;
                    state    <= ACC;
`ifdef HS32_LSU_TIMEOUT_EN
                    tmo_cnt  <= TW'(TIMEOUT);
`endif
                end

                END: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    mem.reqm <= 1'b0;
                end
            endcase
        end
    end

endmodule
